// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   arb_state_e : arbiter FSM states (idle, issue, wait, ack)
//   REQ_CPU/DMA : requester IDs, also the encoding of owner_dma
//   lat_cnt_w() : width of the latency down-counter for a given LAT
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StAck
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // The counter only has to hold LAT-1. The extra bit keeps the width at least 1 when LAT is 1.
  function automatic int unsigned lat_cnt_w(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle around the arbiter: the CPU and DMA request/ack ports, the single-port memory
// strobes and data, and the busy/owner status.
//   slave  : arbiter view (takes requests and mem_rdata, drives acks, strobes and status)
//   master : system view (requesters plus memory; the mirror image of slave)
interface mem_arbiter_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output busy, owner_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  busy, owner_dma
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req[1:0] : request vector, bit REQ_CPU = CPU, bit REQ_DMA = DMA
//   last     : requester granted most recently
//   valid    : at least one request present
//   winner   : chosen requester (don't care when valid = 0)
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = REQ_CPU;
    case (req)
      2'b01:   winner = REQ_CPU;
      2'b10:   winner = REQ_DMA;
      2'b11:   winner = ~last;  // on a tie, the side that did not go last wins
      default: winner = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter that shares the single-port unified memory between the CPU datapath and the DMA/loader
// port. It runs one transaction at a time through IDLE -> ISSUE -> WAIT -> ACK. A request
// sampled in IDLE at cycle t gives a memory strobe at t+1 and a one-cycle ack at t+LAT+2.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_arbiter_if.slave (requester ports, memory port, busy/owner status)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW  = 12,
  parameter int unsigned DW  = 16,
  parameter int unsigned LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned    CW      = lat_cnt_w(LAT);
  localparam logic [CW-1:0]  CntLoad = CW'(LAT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;     // last grant; also serves as the current owner
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic pick_valid;
  logic pick_winner;

  rr_pick2 u_pick (
    .req    ({bus.dma_req, bus.cpu_req}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          last_d = pick_winner;
          if (pick_winner == REQ_DMA) begin
            we_d    = bus.dma_we;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
          end else begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        // Data is valid LAT cycles after the strobe. That is the WAIT cycle in which the
        // counter reads zero. Writes go through the same path so that latency is uniform.
        if (cnt_q == '0) begin
          if (last_q == REQ_DMA) begin
            dma_rdata_d = bus.mem_rdata;
          end else begin
            cpu_rdata_d = bus.mem_rdata;
          end
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= REQ_DMA;  // CPU wins the first tie
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  always_comb begin
    bus.mem_rd    = (state_q == StIssue) & ~we_q;
    bus.mem_wr    = (state_q == StIssue) & we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.cpu_ack   = (state_q == StAck) & (last_q == REQ_CPU);
    bus.dma_ack   = (state_q == StAck) & (last_q == REQ_DMA);
    bus.cpu_rdata = cpu_rdata_q;
    bus.dma_rdata = dma_rdata_q;
    bus.busy      = (state_q != StIdle);
    bus.owner_dma = last_q;
  end

endmodule
